// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host I2C byte commands, issues them one at
// a time to the I2C master controller and returns one response each.
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [6:0]             cmd_addr,
  input  logic [7:0]             cmd_data,
  input  logic                   cmd_rw,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic                   rsp_rw,
  output logic                   rsp_timeout,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   ctl_enable,
  output logic [6:0]             ctl_addr,
  output logic [7:0]             ctl_data_in,
  output logic                   ctl_rw,
  input  logic                   ctl_ready,
  input  logic [7:0]             ctl_data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  // Transition happens on the edge where the timer reaches TIMEOUT.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP
  } state_t;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic [15:0]   head;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ctl_enable_q, ctl_enable_d;
  logic [6:0]    ctl_addr_q, ctl_addr_d;
  logic [7:0]    ctl_data_q, ctl_data_d;
  logic          ctl_rw_q, ctl_rw_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_rw_q, rsp_rw_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  // Pop only when the controller is idle and no response is waiting.
  assign pop = (state_q == S_IDLE) & (count_q != '0)
             & ctl_ready & ~rsp_valid_q;

  // FIFO storage; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_data};
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer next-state: issue, wait for completion, respond.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    ctl_enable_d  = ctl_enable_q;
    ctl_addr_d    = ctl_addr_q;
    ctl_data_d    = ctl_data_q;
    ctl_rw_d      = ctl_rw_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_rw_d      = rsp_rw_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          ctl_rw_d     = head[15];
          ctl_addr_d   = head[14:8];
          ctl_data_d   = head[7:0];
          ctl_enable_d = 1'b1;
          timer_d      = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = timer_q + TW'(1);
        if (!ctl_ready) begin
          // Controller left idle: drop enable so it ends with STOP.
          ctl_enable_d = 1'b0;
          timer_d      = '0;
          state_d      = S_BUSY;
        end else if (timer_q == TLAST) begin
          ctl_enable_d  = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = 8'h00;
          rsp_rw_d      = ctl_rw_q;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_BUSY: begin
        timer_d = timer_q + TW'(1);
        if (ctl_ready) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = ctl_rw_q ? ctl_data_out : 8'h00;
          rsp_rw_d      = ctl_rw_q;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (timer_q == TLAST) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = 8'h00;
          rsp_rw_d      = ctl_rw_q;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      ctl_enable_q  <= 1'b0;
      ctl_addr_q    <= '0;
      ctl_data_q    <= '0;
      ctl_rw_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_rw_q      <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ctl_enable_q  <= ctl_enable_d;
      ctl_addr_q    <= ctl_addr_d;
      ctl_data_q    <= ctl_data_d;
      ctl_rw_q      <= ctl_rw_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_rw_q      <= rsp_rw_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign fifo_count  = count_q;
  assign ctl_enable  = ctl_enable_q;
  assign ctl_addr    = ctl_addr_q;
  assign ctl_data_in = ctl_data_q;
  assign ctl_rw      = ctl_rw_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_rw      = rsp_rw_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: random and directed commands against a
// behavioural controller/slave model and an in-order response scoreboard.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  localparam int M_NORMAL = 0;
  localparam int M_HANG   = 1;
  localparam int M_STUCK  = 2;
  localparam int M_OFF    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_rw = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_rw;
  logic       rsp_timeout;
  logic [2:0] fifo_count;
  logic       ctl_enable;
  logic [6:0] ctl_addr;
  logic [7:0] ctl_data_in;
  logic       ctl_rw;
  logic       ctl_ready = 1'b1;
  logic [7:0] ctl_data_out = '0;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct packed {
    logic       rw;
    logic       to;
    logic [7:0] data;
  } rsp_t;

  cmd_t       iss_q[$];
  rsp_t       exp_q[$];
  logic [7:0] slave_mem [128];
  logic [7:0] model_mem [128];

  int n_tests  = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int rsp_seen = 0;
  int en_rises = 0;
  int mode     = M_NORMAL;
  int rsp_mode = 0;
  int cstate   = 0;

  // controller model state
  int         ccnt = 0;
  logic [6:0] caddr = '0;
  logic [7:0] cdata = '0;
  logic       crw = 1'b0;
  logic       lat = 1'b0;

  // monitor state
  logic       en_prev = 1'b0;
  int         en_len = 0;
  cmd_t       en_cur = '0;
  cmd_t       en_e;
  logic       r_pend = 1'b0;
  logic [9:0] r_held = '0;
  rsp_t       r_e;

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rw(cmd_rw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rw(rsp_rw), .rsp_timeout(rsp_timeout),
    .fifo_count(fifo_count),
    .ctl_enable(ctl_enable), .ctl_addr(ctl_addr),
    .ctl_data_in(ctl_data_in), .ctl_rw(ctl_rw),
    .ctl_ready(ctl_ready), .ctl_data_out(ctl_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_bad();
    return (mode == M_HANG) || (mode == M_STUCK);
  endfunction

  task automatic push_cmd(input logic rw, input logic [6:0] a,
                          input logic [7:0] d);
    int   n;
    cmd_t c;
    rsp_t r;
    n = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("push_to", 32'(cmd_ready), 1);
    end else begin
      c.rw = rw; c.addr = a; c.data = d;
      iss_q.push_back(c);
      r.rw = rw; r.to = is_bad(); r.data = 8'h00;
      if (!is_bad()) begin
        if (rw) r.data = model_mem[a];
        else    model_mem[a] = d;
      end
      exp_q.push_back(r);
      n_push++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cstate != 0 || fifo_count != 0)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  // Controller + slave model, acting on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      case (cstate)
        0: begin
          if (lat) begin
            check("rsp_lat", 32'(rsp_valid), 1);
            lat = 1'b0;
          end
          ctl_ready = (mode != M_OFF);
          if (ctl_enable && (mode == M_NORMAL || mode == M_STUCK)) begin
            ccnt   = $urandom_range(0, 2);
            cstate = 1;
          end
        end
        1: begin
          if (ccnt == 0) begin
            caddr     = ctl_addr;
            cdata     = ctl_data_in;
            crw       = ctl_rw;
            ctl_ready = 1'b0;
            ccnt      = (mode == M_STUCK) ? 40 : $urandom_range(3, 10);
            cstate    = 2;
          end else begin
            ccnt--;
          end
        end
        default: begin
          check("en_busy", 32'(ctl_enable), 0);
          ctl_data_out = 8'($urandom);
          if (ccnt == 0) begin
            if (mode == M_NORMAL) begin
              if (crw) ctl_data_out = slave_mem[caddr];
              else     slave_mem[caddr] = cdata;
              lat = 1'b1;
            end
            ctl_ready = 1'b1;
            cstate    = 0;
          end else begin
            ccnt--;
          end
        end
      endcase
    end
  end

  // Issue monitor: order, stability and hang-timeout pulse length.
  initial begin
    forever begin
      @(negedge clk);
      if (ctl_enable && !en_prev) begin
        en_rises++;
        en_len = 1;
        if (iss_q.size() == 0) begin
          check("iss_unexp", 32'(ctl_enable), 0);
        end else begin
          en_e   = iss_q.pop_front();
          en_cur = en_e;
          check("iss_addr", 32'(ctl_addr), 32'(en_e.addr));
          check("iss_data", 32'(ctl_data_in), 32'(en_e.data));
          check("iss_rw", 32'(ctl_rw), 32'(en_e.rw));
        end
      end else if (ctl_enable) begin
        en_len++;
        check("iss_stable", 32'({ctl_rw, ctl_addr, ctl_data_in}),
              32'(en_cur));
      end else if (en_prev && mode == M_HANG) begin
        check("to_len", 32'(en_len), TMO);
      end
      en_prev = ctl_enable;
    end
  end

  // Response side: drives rsp_ready and scores responses in order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) r_pend = 1'b0;
      if (r_pend) begin
        check("rsp_hold_v", 32'(rsp_valid), 1);
        if (rsp_valid)
          check("rsp_hold_d", 32'({rsp_rw, rsp_timeout, rsp_data}),
                32'(r_held));
      end
      case (rsp_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 9) < 7);
      endcase
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexp", 32'(rsp_valid), 0);
        end else begin
          r_e = exp_q.pop_front();
          check("rsp_rw", 32'(rsp_rw), 32'(r_e.rw));
          check("rsp_timeout", 32'(rsp_timeout), 32'(r_e.to));
          check("rsp_data", 32'(rsp_data), 32'(r_e.data));
        end
        rsp_seen++;
        r_pend = 1'b0;
      end else begin
        r_pend = rsp_valid;
        r_held = {rsp_rw, rsp_timeout, rsp_data};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int last;
    int n;
    for (int i = 0; i < 128; i++) begin
      slave_mem[i] = 8'($urandom);
      model_mem[i] = slave_mem[i];
    end
    slave_mem[7'h51] = 8'h3C;
    model_mem[7'h51] = 8'h3C;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_rw", 32'(rsp_rw), 0);
    check("rst_rsp_to", 32'(rsp_timeout), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_en", 32'(ctl_enable), 0);
    check("rst_addr", 32'(ctl_addr), 0);
    check("rst_din", 32'(ctl_data_in), 0);
    check("rst_rw", 32'(ctl_rw), 0);
    rst = 1'b0;
    @(negedge clk);

    // single write then single read
    rsp_mode = 2;
    push_cmd(1'b0, 7'h50, 8'hA5);
    drain();
    push_cmd(1'b1, 7'h51, 8'h00);
    drain();

    // fill the FIFO while the controller is busy elsewhere
    mode = M_OFF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      push_cmd(1'($urandom_range(0, 1)), 7'(7'h50 + i), 8'($urandom));
    check("full_rdy", 32'(cmd_ready), 0);
    check("full_cnt", 32'(fifo_count), 4);
    mode = M_NORMAL;
    last = 4;
    n = 0;
    while (fifo_count != 0 && n < 1000) begin
      @(negedge clk);
      n++;
      if (32'(fifo_count) != last) begin
        check("cnt_dec", 32'(fifo_count), 32'(last - 1));
        last = 32'(fifo_count);
      end
    end
    check("cnt_zero", 32'(fifo_count), 0);
    drain();

    // pending response blocks further issue
    rsp_mode = 1;
    base = en_rises;
    push_cmd(1'b1, 7'h52, 8'h00);
    push_cmd(1'b0, 7'h53, 8'h77);
    repeat (50) @(negedge clk);
    check("hold_iss", 32'(en_rises - base), 1);
    check("hold_valid", 32'(rsp_valid), 1);
    check("hold_cnt", 32'(fifo_count), 1);
    rsp_mode = 0;
    drain();

    // controller never starts: ISSUE timeout
    mode = M_HANG;
    push_cmd(1'b0, 7'h52, 8'h11);
    push_cmd(1'b1, 7'h53, 8'h00);
    drain();
    mode = M_NORMAL;

    // controller stuck busy: BUSY timeout
    mode = M_STUCK;
    push_cmd(1'b1, 7'h50, 8'h00);
    push_cmd(1'b0, 7'h51, 8'h22);
    drain();
    mode = M_NORMAL;

    // random traffic
    rsp_mode = 0;
    for (int i = 0; i < 40; i++) begin
      push_cmd(1'($urandom_range(0, 1)),
               7'(7'h50 + $urandom_range(0, 3)), 8'($urandom));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();
    check("rsp_count", 32'(rsp_seen), 32'(n_push));

    // reset while BUSY with two entries queued
    mode = M_STUCK;
    push_cmd(1'b1, 7'h50, 8'h00);
    push_cmd(1'b1, 7'h51, 8'h00);
    push_cmd(1'b1, 7'h52, 8'h00);
    n = 0;
    while (!(ctl_ready == 1'b0 && ctl_enable == 1'b0 && fifo_count == 2)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_cnt", 32'(fifo_count), 2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_en", 32'(ctl_enable), 0);
    check("mid_rst_cnt", 32'(fifo_count), 0);
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_rdy", 32'(cmd_ready), 1);
    iss_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    base = en_rises;
    repeat (80) @(negedge clk);
    check("post_rst_iss", 32'(en_rises - base), 0);
    check("post_rst_valid", 32'(rsp_valid), 0);
    check("post_rst_cnt", 32'(fifo_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
